// File: rtl/wb_commit_trace.sv
// Write-back commit trace: captures qualifying register-file writes into a
// show-ahead FIFO drained by a debug consumer, with commit and drop counters.
module wb_commit_trace #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter bit SKIP_R0 = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RegWrite_In,
  input  logic [4:0]        RegDest_In,
  input  logic [31:0]       WriteData_In,
  input  logic [31:0]       PC_In,
  input  logic              Pop_In,
  input  logic              Clear_In,
  output logic              Valid_Out,
  output logic [31:0]       Entry_PC_Out,
  output logic [4:0]        Entry_Dest_Out,
  output logic [31:0]       Entry_Data_Out,
  output logic [ADDR_W:0]   Count_Out,
  output logic              Overflow_Out,
  output logic [15:0]       DropCount_Out,
  output logic [31:0]       CommitCount_Out
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  entry_t            new_entry;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic              commit;
  logic              not_empty;
  logic              full;
  logic              do_pop;
  logic              do_push;
  logic              do_drop;

  always_comb begin
    commit    = RegWrite_In && !(SKIP_R0 && (RegDest_In == 5'd0));
    not_empty = (count != '0);
    full      = (count == FULL_COUNT);
    do_pop    = Pop_In && not_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push   = commit && (!full || do_pop);
    do_drop   = commit && full && !do_pop;
    new_entry = '{pc: PC_In, dest: RegDest_In, data: WriteData_In};
  end

  always_ff @(posedge Clock) begin
    if (!Reset && !Clear_In && do_push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      Overflow_Out    <= 1'b0;
      DropCount_Out   <= '0;
      CommitCount_Out <= '0;
    end else begin
      // The commit counter survives Clear; only Reset zeroes it.
      if (commit) begin
        CommitCount_Out <= CommitCount_Out + 32'd1;
      end
      if (Clear_In) begin
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        count         <= '0;
        Overflow_Out  <= 1'b0;
        DropCount_Out <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (do_push && !do_pop) begin
          count <= count + 1'b1;
        end else if (do_pop && !do_push) begin
          count <= count - 1'b1;
        end
        if (do_drop) begin
          Overflow_Out <= 1'b1;
          if (DropCount_Out != 16'hFFFF) begin
            DropCount_Out <= DropCount_Out + 16'd1;
          end
        end
      end
    end
  end

  always_comb begin
    head           = mem[rd_ptr];
    Valid_Out      = not_empty;
    Count_Out      = count;
    Entry_PC_Out   = not_empty ? head.pc   : '0;
    Entry_Dest_Out = not_empty ? head.dest : '0;
    Entry_Data_Out = not_empty ? head.data : '0;
  end

endmodule
